// File: rtl/hash_scheduler_if.sv
// Single-beat-capable AXI-stream bundle shared by the
// message input and the digest output of hash_scheduler.
interface hash_scheduler_if #(
    parameter int DATA_WIDTH  = 512,
    parameter int TUSER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (
        output tdata, tkeep, tuser, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tuser, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/hash_scheduler.sv
// Round-robin dispatcher of a message stream onto a pool of
// hash engines, returning digests in message-arrival order.
module hash_scheduler #(
    parameter int NUM_ENGINES = 4,
    parameter int ID_WIDTH    = 2,
    parameter int DATA_WIDTH  = 512,
    parameter int TUSER_WIDTH = 128
) (
    input  logic                                axi_aclk,
    input  logic                                axi_resetn,
    hash_scheduler_if.slave                     s_axis,
    hash_scheduler_if.master                    m_axis,
    output logic [DATA_WIDTH-1:0]               eng_tdata,
    output logic [NUM_ENGINES-1:0]              eng_tvalid,
    output logic                                eng_tlast,
    input  logic [NUM_ENGINES-1:0]              eng_tready,
    output logic [NUM_ENGINES-1:0]              eng_en,
    output logic [2*NUM_ENGINES-1:0]            eng_sha_type,
    input  logic [NUM_ENGINES*DATA_WIDTH-1:0]   dig_tdata,
    input  logic [NUM_ENGINES*DATA_WIDTH/8-1:0] dig_tkeep,
    input  logic [NUM_ENGINES-1:0]              dig_tvalid,
    output logic [NUM_ENGINES-1:0]              dig_tready
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [ID_WIDTH-1:0]      sel_q, sel_d;
    logic [ID_WIDTH-1:0]      rr_q, rr_d;
    logic [NUM_ENGINES-1:0]   busy_q, busy_d;
    logic [2*NUM_ENGINES-1:0] sha_q, sha_d;

    logic [ID_WIDTH-1:0]      fifo_q [NUM_ENGINES];
    logic [ID_WIDTH-1:0]      fifo_d [NUM_ENGINES];
    logic [ID_WIDTH-1:0]      wr_q, wr_d;
    logic [ID_WIDTH-1:0]      rd_q, rd_d;
    logic [ID_WIDTH:0]        cnt_q, cnt_d;

    logic                     found;
    logic [ID_WIDTH-1:0]      pick;
    logic [ID_WIDTH-1:0]      head;
    logic                     empty;
    logic                     push;
    logic                     pop;

    // First free engine at or after rr_q; wraps because N is a power of 2.
    always_comb begin
        logic [ID_WIDTH-1:0] idx;
        found = 1'b0;
        pick  = rr_q;
        idx   = rr_q;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            idx = rr_q + ID_WIDTH'(k);
            if (!found && !busy_q[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rd_q];
    assign pop   = m_axis.tvalid & m_axis.tready;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        rr_d          = rr_q;
        busy_d        = busy_q;
        sha_d         = sha_q;
        push          = 1'b0;
        eng_tvalid    = '0;
        s_axis.tready = 1'b0;

        if (pop) begin
            busy_d[head] = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (s_axis.tvalid && found) begin
                    busy_d[pick]              = 1'b1;
                    sha_d[2*int'(pick) +: 2]  = s_axis.tuser[1:0];
                    rr_d                      = pick + 1'b1;
                    sel_d                     = pick;
                    state_d                   = STREAM;
                end
            end
            STREAM: begin
                eng_tvalid[sel_q] = s_axis.tvalid;
                s_axis.tready     = eng_tready[sel_q];
                if (s_axis.tvalid && eng_tready[sel_q] && s_axis.tlast) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Order FIFO; a push always names a busy engine not yet queued.
    always_comb begin
        fifo_d = fifo_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        if (push) begin
            fifo_d[wr_q] = sel_q;
            wr_d         = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        dig_tready       = '0;
        dig_tready[head] = !empty & m_axis.tready;
    end

    always_comb begin
        m_axis.tuser                 = '0;
        m_axis.tuser[ID_WIDTH+1:0]   = {head, sha_q[2*int'(head) +: 2]};
    end

    assign m_axis.tvalid = !empty & dig_tvalid[head];
    assign m_axis.tlast  = m_axis.tvalid;
    assign m_axis.tdata  = dig_tdata[int'(head)*DATA_WIDTH +: DATA_WIDTH];
    assign m_axis.tkeep  = dig_tkeep[int'(head)*(DATA_WIDTH/8) +: DATA_WIDTH/8];

    assign eng_tdata    = s_axis.tdata;
    assign eng_tlast    = s_axis.tlast;
    assign eng_en       = busy_q;
    assign eng_sha_type = sha_q;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rr_q    <= '0;
            busy_q  <= '0;
            sha_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < NUM_ENGINES; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
            sha_q   <= sha_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            fifo_q  <= fifo_d;
        end
    end

endmodule

// File: tb/tb_hash_scheduler.sv
// Directed bench for hash_scheduler: dispatch table plus
// hand sequences for ordering, stalls and async reset.
module tb_hash_scheduler;

    localparam int N  = 4;
    localparam int DW = 512;
    localparam int TW = 128;

    logic clk;
    logic rst_n;

    logic [DW-1:0]       eng_tdata;
    logic [N-1:0]        eng_tvalid;
    logic                eng_tlast;
    logic [N-1:0]        eng_tready;
    logic [N-1:0]        eng_en;
    logic [2*N-1:0]      eng_sha_type;
    logic [N*DW-1:0]     dig_tdata;
    logic [N*DW/8-1:0]   dig_tkeep;
    logic [N-1:0]        dig_tvalid;
    logic [N-1:0]        dig_tready;

    int checks;
    int failures;

    hash_scheduler_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(TW)) s_if ();
    hash_scheduler_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(TW)) m_if ();

    hash_scheduler #(
        .NUM_ENGINES(N), .ID_WIDTH(2),
        .DATA_WIDTH(DW), .TUSER_WIDTH(TW)
    ) dut (
        .axi_aclk     (clk),
        .axi_resetn   (rst_n),
        .s_axis       (s_if.slave),
        .m_axis       (m_if.master),
        .eng_tdata    (eng_tdata),
        .eng_tvalid   (eng_tvalid),
        .eng_tlast    (eng_tlast),
        .eng_tready   (eng_tready),
        .eng_en       (eng_en),
        .eng_sha_type (eng_sha_type),
        .dig_tdata    (dig_tdata),
        .dig_tkeep    (dig_tkeep),
        .dig_tvalid   (dig_tvalid),
        .dig_tready   (dig_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sha;
        int         beats;
        int         exp_eng;
    } vec_t;

    function automatic logic [63:0] exp_data(input int i);
        logic [31:0] w;
        w = 32'hD000_0000 + 32'(i);
        return {w, w};
    endfunction

    function automatic logic [63:0] exp_keep(input int i);
        logic [7:0] b;
        b = 8'hA0 + 8'(i);
        return {8{b}};
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        dig_tvalid  = '0;
        m_if.tready = 1'b1;
        eng_tready  = '1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives one message from a negedge; returns engine of first beat.
    task automatic send_msg(input logic [1:0] sha, input int beats,
                            output int eng);
        int b;
        int t;
        b = 0;
        t = 0;
        eng = -1;
        s_if.tvalid = 1'b1;
        s_if.tuser  = TW'(sha);
        s_if.tlast  = (beats == 1);
        s_if.tdata  = '0;
        while (b < beats && t < 200) begin
            #1;
            if (s_if.tready) begin
                if (b == 0) eng = onehot_idx(eng_tvalid);
                b++;
            end
            @(negedge clk);
            t++;
            s_if.tdata = DW'(b);
            s_if.tlast = (b == beats - 1);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        if (b < beats) begin
            failures++;
            checks++;
            $display("FAIL send_timeout actual=%0d expected=%0d", b, beats);
        end
    endtask

    initial begin
        vec_t vecs[4];
        int   eng;
        int   n;
        int   id;
        int   exp_order[3];
        int   beats;
        logic [4:0] hs;
        logic [4:0] pat;
        logic stall_ok;
        logic [DW-1:0] d0;
        logic [DW/8-1:0] k0;
        logic [TW-1:0] u0;

        checks   = 0;
        failures = 0;
        s_if.tdata = '0;
        s_if.tkeep = '0;
        s_if.tuser = '0;
        for (int i = 0; i < N; i++) begin
            dig_tdata[i*DW +: DW]       = {8{exp_data(i)}};
            dig_tkeep[i*DW/8 +: DW/8]   = exp_keep(i);
        end

        vecs[0] = '{2'd0, 1, 0};
        vecs[1] = '{2'd1, 2, 1};
        vecs[2] = '{2'd2, 1, 2};
        vecs[3] = '{2'd3, 3, 3};
        exp_order = '{0, 1, 2};

        // 1: reset state and single SHA256 message
        do_reset();
        #1;
        check("rst_s_tready", 64'(s_if.tready), 0);
        check("rst_m_tvalid", 64'(m_if.tvalid), 0);
        check("rst_eng_en", 64'(eng_en), 0);
        check("rst_sha_type", 64'(eng_sha_type), 0);
        check("rst_eng_tvalid", 64'(eng_tvalid), 0);
        check("rst_dig_tready", 64'(dig_tready), 0);
        @(negedge clk);
        send_msg(2'd1, 1, eng);
        check("t1_engine", 64'(eng), 0);
        check("t1_eng_en", 64'(eng_en), 64'h1);
        check("t1_sha0", 64'(eng_sha_type[1:0]), 64'h1);
        dig_tvalid = 4'b0001;
        #1;
        check("t1_m_tvalid", 64'(m_if.tvalid), 1);
        check("t1_m_tuser", 64'(m_if.tuser[3:0]), 64'h1);
        check("t1_dig_tready", 64'(dig_tready), 64'h1);
        check("t1_m_tdata", m_if.tdata[63:0], exp_data(0));
        check("t1_m_tkeep", m_if.tkeep, exp_keep(0));
        check("t1_m_tlast", 64'(m_if.tlast), 1);
        @(negedge clk);
        dig_tvalid = '0;
        #1;
        check("t1_busy_clr", 64'(eng_en), 0);
        check("t1_m_tvalid_off", 64'(m_if.tvalid), 0);
        @(negedge clk);

        // 2: table-driven dispatch to engines 0..3
        do_reset();
        for (int v = 0; v < 4; v++) begin
            send_msg(vecs[v].sha, vecs[v].beats, eng);
            check($sformatf("t2_eng_%0d", v), 64'(eng),
                  64'(vecs[v].exp_eng));
            check($sformatf("t2_sha_%0d", v),
                  64'(eng_sha_type[2*vecs[v].exp_eng +: 2]),
                  64'(vecs[v].sha));
        end
        check("t2_all_busy", 64'(eng_en), 64'hF);
        s_if.tvalid = 1'b1;
        s_if.tuser  = TW'(1);
        s_if.tlast  = 1'b1;
        stall_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (s_if.tready !== 1'b0 || eng_tvalid !== '0) stall_ok = 1'b0;
            @(negedge clk);
        end
        check("t2_stall", 64'(stall_ok), 1);
        dig_tvalid = 4'b0001;
        #1;
        check("t2_pop_tuser", 64'(m_if.tuser[3:0]), 64'h0);
        @(negedge clk);
        dig_tvalid = '0;
        send_msg(2'd1, 1, eng);
        check("t2_fifth_eng", 64'(eng), 0);
        check("t2_fifth_sha", 64'(eng_sha_type[1:0]), 64'h1);

        // 3: reverse-order digest completion returns in order
        do_reset();
        for (int v = 0; v < 3; v++) send_msg(2'd1, 1, eng);
        dig_tvalid = 4'b0100;
        #1;
        check("t3_wait2_tvalid", 64'(m_if.tvalid), 0);
        check("t3_wait2_dready", 64'(dig_tready), 64'h1);
        @(negedge clk);
        dig_tvalid = 4'b0110;
        #1;
        check("t3_wait1_tvalid", 64'(m_if.tvalid), 0);
        @(negedge clk);
        dig_tvalid = 4'b0111;
        n = 0;
        for (int c = 0; c < 10 && n < 3; c++) begin
            #1;
            if (m_if.tvalid) begin
                id = int'(m_if.tuser[3:2]);
                check($sformatf("t3_order_%0d", n), 64'(id),
                      64'(exp_order[n]));
                check($sformatf("t3_dready_%0d", n), 64'(dig_tready),
                      64'(1 << exp_order[n]));
                check($sformatf("t3_data_%0d", n), m_if.tdata[63:0],
                      exp_data(exp_order[n]));
                n++;
                @(negedge clk);
                dig_tvalid[id] = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        check("t3_count", 64'(n), 3);

        // 4: 3-beat message under toggling eng_tready
        do_reset();
        pat = 5'b10101;
        hs  = '0;
        beats = 0;
        s_if.tvalid = 1'b1;
        s_if.tuser  = TW'(2);
        s_if.tlast  = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            eng_tready = pat[k] ? '1 : '0;
            #1;
            if (s_if.tready && s_if.tvalid && eng_tvalid == 4'b0001) begin
                hs[k] = 1'b1;
                beats++;
            end
            @(negedge clk);
            s_if.tlast = (beats == 2);
            if (beats == 3) s_if.tvalid = 1'b0;
        end
        check("t4_beats", 64'(beats), 3);
        check("t4_hs_cycles", 64'(hs), 64'h15);
        eng_tready  = '1;
        s_if.tvalid = 1'b1;
        s_if.tlast  = 1'b1;
        #1;
        check("t4_idle_after", 64'(s_if.tready), 0);
        @(negedge clk);
        send_msg(2'd3, 1, eng);
        check("t4_next_eng", 64'(eng), 1);

        // 5: output backpressure holds the head digest
        m_if.tready = 1'b0;
        dig_tvalid  = 4'b0001;
        #1;
        d0 = m_if.tdata;
        k0 = m_if.tkeep;
        u0 = m_if.tuser;
        check("t5_tuser", 64'(u0[3:0]), 64'h2);
        stall_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (m_if.tdata !== d0 || m_if.tkeep !== k0 ||
                m_if.tuser !== u0 || m_if.tvalid !== 1'b1 ||
                dig_tready !== '0 || eng_en !== 4'b0011)
                stall_ok = 1'b0;
        end
        check("t5_stable", 64'(stall_ok), 1);
        @(negedge clk);
        m_if.tready = 1'b1;
        #1;
        check("t5_release_dready", 64'(dig_tready), 64'h1);
        @(negedge clk);
        dig_tvalid = '0;
        #1;
        check("t5_one_pop", 64'(eng_en), 64'h2);
        check("t5_next_head", 64'(m_if.tuser[3:2]), 64'h1);
        @(negedge clk);

        // 6: async reset in the middle of a message
        dig_tvalid  = 4'b0010;
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tuser  = TW'(1);
        s_if.tlast  = 1'b0;
        @(negedge clk);
        #1;
        check("t6_beat1_eng", 64'(eng_tvalid), 64'h4);
        @(negedge clk);
        #1;
        check("t6_pre_m_tvalid", 64'(m_if.tvalid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_s_tready", 64'(s_if.tready), 0);
        check("t6_rst_eng_tvalid", 64'(eng_tvalid), 0);
        check("t6_rst_eng_en", 64'(eng_en), 0);
        check("t6_rst_sha", 64'(eng_sha_type), 0);
        check("t6_rst_m_tvalid", 64'(m_if.tvalid), 0);
        check("t6_rst_dready", 64'(dig_tready), 0);
        do_reset();
        send_msg(2'd2, 1, eng);
        check("t6_after_eng", 64'(eng), 0);
        check("t6_after_sha", 64'(eng_sha_type[1:0]), 64'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
